// File: rtl/fm_stat_pkg.sv
// Shared encodings and helpers for the feature-map statistics engine.
// Mode and FSM state enums plus the output saturation check.
package fm_stat_pkg;

  typedef enum logic [1:0] {
    MODE_RANGE = 2'd0,
    MODE_SQ    = 2'd1,
    MODE_ABS   = 2'd2,
    MODE_SUM   = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_ACC,
    ST_DRAIN,
    ST_SCALE,
    ST_BIAS,
    ST_HOLD
  } state_e;

  localparam int SAT_W = 128;

  // Returns {above_max, below_min} for a signed value clamped to dw bits.
  function automatic logic [1:0] sat_clip(input logic signed [SAT_W-1:0] v, input int dw);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi         = '0;
    hi[dw-1]   = 1'b1;
    hi         = hi - SAT_W'(1);
    lo         = ~hi;
    sat_clip   = {v > hi, v < lo};
  endfunction

endpackage

// File: rtl/fm_lane_reduce.sv
// Stage 1: registered per-beat reduction across N lanes.
// Produces lane max/min with lowest-lane tie-break and the three per-beat sums.
module fm_lane_reduce
  import fm_stat_pkg::*;
#(
  parameter int DW   = 16,
  parameter int N    = 8,
  parameter int FRAC = 8,
  parameter int LW   = $clog2(N),
  parameter int SW   = 2*DW + $clog2(N)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [N*DW-1:0] i_x,
  input  logic            i_valid,
  input  logic            i_first,
  output logic            o_valid,
  output logic            o_first,
  output logic [DW-1:0]   o_max,
  output logic [LW-1:0]   o_max_lane,
  output logic [DW-1:0]   o_min,
  output logic [LW-1:0]   o_min_lane,
  output logic [SW-1:0]   o_sum_sq,
  output logic [SW-1:0]   o_sum_abs,
  output logic [SW-1:0]   o_sum
);

  logic signed [DW-1:0] w_max, w_min;
  logic [LW-1:0]        w_max_lane, w_min_lane;
  logic signed [SW-1:0] w_sum_sq, w_sum_abs, w_sum;

  // NOTE: every variable gets a value before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    logic signed [DW-1:0]   v;
    logic signed [DW:0]     vx;
    logic signed [2*DW-1:0] sq;
    w_max      = $signed(i_x[DW-1:0]);
    w_min      = w_max;
    w_max_lane = '0;
    w_min_lane = '0;
    w_sum_sq   = '0;
    w_sum_abs  = '0;
    w_sum      = '0;
    v          = '0;
    vx         = '0;
    sq         = '0;
    for (int i = 0; i < N; i++) begin
      v  = $signed(i_x[i*DW +: DW]);
      // One extra bit so |most-negative| is representable.
      vx = {v[DW-1], v};
      sq = (v * v) >>> FRAC;
      if (v > w_max) begin
        w_max      = v;
        w_max_lane = LW'(i);
      end
      if (v < w_min) begin
        w_min      = v;
        w_min_lane = LW'(i);
      end
      w_sum_sq  = w_sum_sq + SW'(sq);
      w_sum_abs = w_sum_abs + SW'(vx[DW] ? -vx : vx);
      w_sum     = w_sum + SW'(v);
    end
  end

  // NOTE: registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_valid    <= 1'b0;
      o_first    <= 1'b0;
      o_max      <= '0;
      o_max_lane <= '0;
      o_min      <= '0;
      o_min_lane <= '0;
      o_sum_sq   <= '0;
      o_sum_abs  <= '0;
      o_sum      <= '0;
    end else begin
      o_valid <= i_valid;
      o_first <= i_valid & i_first;
      if (i_valid) begin
        o_max      <= w_max;
        o_max_lane <= w_max_lane;
        o_min      <= w_min;
        o_min_lane <= w_min_lane;
        o_sum_sq   <= w_sum_sq;
        o_sum_abs  <= w_sum_abs;
        o_sum      <= w_sum;
      end
    end
  end

endmodule

// File: rtl/fm_stat_engine.sv
// Streaming per-frame statistics engine: reduces a frame of N-lane beats to one
// scalar, then applies out = sat(acc*scale + bias) with argmax/argmin reporting.
module fm_stat_engine
  import fm_stat_pkg::*;
#(
  parameter int DW     = 16,
  parameter int N      = 8,
  parameter int FRAC   = 8,
  parameter int ACC_W  = 48,
  parameter int BEAT_W = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [1:0]           mode,
  input  logic [N*DW-1:0]      x,
  input  logic                 x_valid,
  input  logic                 x_last,
  output logic                 x_ready,
  input  logic [DW-1:0]        scale,
  input  logic [DW-1:0]        bias,
  output logic [DW-1:0]        out,
  output logic [$clog2(N)-1:0] max_lane,
  output logic [BEAT_W-1:0]    max_beat,
  output logic [$clog2(N)-1:0] min_lane,
  output logic [BEAT_W-1:0]    min_beat,
  output logic                 out_ovf,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int LW = $clog2(N);
  localparam int SW = 2*DW + LW;
  localparam int PW = ACC_W + DW;
  localparam logic [BEAT_W-1:0] BEAT_MAX = '1;

  state_e               r_state, w_next;
  logic                 r_rdy, r_in_frame, w_accept;
  mode_e                r_mode;
  logic signed [DW-1:0] r_scale, r_bias;

  logic                 w_s1_valid, w_s1_first;
  logic signed [DW-1:0] w_s1_max, w_s1_min;
  logic [LW-1:0]        w_s1_max_lane, w_s1_min_lane;
  logic signed [SW-1:0] w_s1_sum_sq, w_s1_sum_abs, w_s1_sum;

  assign w_accept  = x_valid & r_rdy;
  assign x_ready   = r_rdy;
  assign out_valid = (r_state == ST_HOLD);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_ACC:   if (w_accept && x_last) w_next = ST_DRAIN;
      ST_DRAIN: w_next = ST_SCALE;
      ST_SCALE: w_next = ST_BIAS;
      ST_BIAS:  w_next = ST_HOLD;
      ST_HOLD:  if (out_ready) w_next = ST_ACC;
      default:  w_next = ST_ACC;
    endcase
  end

  // Frame parameters are captured only with the first beat of each frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_ACC;
      r_rdy      <= 1'b0;
      r_in_frame <= 1'b0;
      r_mode     <= MODE_RANGE;
      r_scale    <= '0;
      r_bias     <= '0;
    end else begin
      r_state <= w_next;
      r_rdy   <= (w_next == ST_ACC);
      if (w_accept) begin
        r_in_frame <= !x_last;
        if (!r_in_frame) begin
          r_mode  <= mode_e'(mode);
          r_scale <= $signed(scale);
          r_bias  <= $signed(bias);
        end
      end
    end
  end

  fm_lane_reduce #(.DW(DW), .N(N), .FRAC(FRAC), .LW(LW), .SW(SW)) u_lane_reduce (
    .clk        (clk),
    .rstn       (rstn),
    .i_x        (x),
    .i_valid    (w_accept),
    .i_first    (!r_in_frame),
    .o_valid    (w_s1_valid),
    .o_first    (w_s1_first),
    .o_max      (w_s1_max),
    .o_max_lane (w_s1_max_lane),
    .o_min      (w_s1_min),
    .o_min_lane (w_s1_min_lane),
    .o_sum_sq   (w_s1_sum_sq),
    .o_sum_abs  (w_s1_sum_abs),
    .o_sum      (w_s1_sum)
  );

  logic signed [ACC_W-1:0] r_acc, w_beat_sum, w_acc_sum;
  logic                    w_acc_wrap;
  logic signed [DW-1:0]    r_fmax, r_fmin;
  logic [LW-1:0]           r_fmax_lane, r_fmin_lane;
  logic [BEAT_W-1:0]       r_fmax_beat, r_fmin_beat, r_beat_cnt;
  logic                    r_beat_sat, r_frame_ovf;

  always_comb begin
    w_beat_sum = '0;
    case (r_mode)
      MODE_SQ:  w_beat_sum = ACC_W'(w_s1_sum_sq);
      MODE_ABS: w_beat_sum = ACC_W'(w_s1_sum_abs);
      MODE_SUM: w_beat_sum = ACC_W'(w_s1_sum);
      default:  w_beat_sum = '0;
    endcase
  end

  assign w_acc_sum  = r_acc + w_beat_sum;
  assign w_acc_wrap = (r_acc[ACC_W-1] == w_beat_sum[ACC_W-1]) &&
                      (w_acc_sum[ACC_W-1] != r_acc[ACC_W-1]);

  // Stage 2: strict compares keep the earliest beat on ties.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_acc       <= '0;
      r_fmax      <= '0;
      r_fmin      <= '0;
      r_fmax_lane <= '0;
      r_fmin_lane <= '0;
      r_fmax_beat <= '0;
      r_fmin_beat <= '0;
      r_beat_cnt  <= '0;
      r_beat_sat  <= 1'b0;
      r_frame_ovf <= 1'b0;
    end else if (r_state == ST_HOLD && out_ready) begin
      r_acc       <= '0;
      r_beat_cnt  <= '0;
      r_beat_sat  <= 1'b0;
      r_frame_ovf <= 1'b0;
    end else if (w_s1_valid) begin
      if (r_mode != MODE_RANGE) begin
        r_acc <= w_acc_sum;
        if (w_acc_wrap) r_frame_ovf <= 1'b1;
      end
      if (w_s1_first || w_s1_max > r_fmax) begin
        r_fmax      <= w_s1_max;
        r_fmax_lane <= w_s1_max_lane;
        r_fmax_beat <= r_beat_cnt;
      end
      if (w_s1_first || w_s1_min < r_fmin) begin
        r_fmin      <= w_s1_min;
        r_fmin_lane <= w_s1_min_lane;
        r_fmin_beat <= r_beat_cnt;
      end
      if (r_beat_sat)                   r_frame_ovf <= 1'b1;
      else if (r_beat_cnt == BEAT_MAX)  r_beat_sat  <= 1'b1;
      else                              r_beat_cnt  <= r_beat_cnt + BEAT_W'(1);
    end
  end

  logic signed [DW:0]      w_range;
  logic signed [ACC_W-1:0] w_acc_sel;
  logic signed [PW-1:0]    w_prod, r_p, w_r;
  logic [1:0]              w_clip;

  assign w_range   = {r_fmax[DW-1], r_fmax} - {r_fmin[DW-1], r_fmin};
  assign w_acc_sel = (r_mode == MODE_RANGE) ? ACC_W'(w_range) : r_acc;
  assign w_prod    = PW'(w_acc_sel) * PW'(r_scale);
  assign w_r       = r_p + PW'(r_bias);
  assign w_clip    = sat_clip(SAT_W'(w_r), DW);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_p      <= '0;
      out      <= '0;
      out_ovf  <= 1'b0;
      max_lane <= '0;
      max_beat <= '0;
      min_lane <= '0;
      min_beat <= '0;
    end else begin
      if (r_state == ST_SCALE) r_p <= w_prod >>> FRAC;
      if (r_state == ST_BIAS) begin
        if (w_clip[1])      out <= {1'b0, {(DW-1){1'b1}}};
        else if (w_clip[0]) out <= {1'b1, {(DW-1){1'b0}}};
        else                out <= w_r[DW-1:0];
        out_ovf  <= r_frame_ovf | (|w_clip);
        max_lane <= r_fmax_lane;
        max_beat <= r_fmax_beat;
        min_lane <= r_fmin_lane;
        min_beat <= r_fmin_beat;
      end
    end
  end

endmodule

// File: tb/tb_fm_stat_engine.sv
// Self-checking bench for fm_stat_engine: frames are modelled when driven,
// expected results queued, and compared when out_valid is seen.
module tb_fm_stat_engine;

  logic         clk = 1'b0;
  logic         rstn;
  logic [1:0]   mode;
  logic [127:0] x;
  logic         x_valid, x_last, x_ready;
  logic [15:0]  scale, bias, out;
  logic [2:0]   max_lane, min_lane;
  logic [15:0]  max_beat, min_beat;
  logic         out_ovf, out_valid, out_ready;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] out;
    logic [2:0]  max_lane;
    logic [15:0] max_beat;
    logic [2:0]  min_lane;
    logic [15:0] min_beat;
    logic        ovf;
  } exp_t;

  exp_t         sb_q[$];
  logic [127:0] beats_q[$];

  always #5 clk = ~clk;

  fm_stat_engine #(.DW(16), .N(8), .FRAC(8), .ACC_W(48), .BEAT_W(16)) dut (
    .clk(clk), .rstn(rstn), .mode(mode), .x(x), .x_valid(x_valid), .x_last(x_last),
    .x_ready(x_ready), .scale(scale), .bias(bias), .out(out), .max_lane(max_lane),
    .max_beat(max_beat), .min_lane(min_lane), .min_beat(min_beat), .out_ovf(out_ovf),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  function automatic logic [127:0] beat_all(input logic [15:0] v);
    logic [127:0] b;
    for (int l = 0; l < 8; l++) b[l*16 +: 16] = v;
    return b;
  endfunction

  // Reference model of one frame, computed from the beats about to be driven.
  task automatic push_expected(input logic [1:0] m, input logic [15:0] sc, input logic [15:0] bi);
    exp_t         e;
    logic [127:0] bt;
    longint       acc, p, r;
    int           v, mx, mn;
    acc = 0; mx = 0; mn = 0;
    e = '{default: '0};
    for (int b = 0; b < beats_q.size(); b++) begin
      bt = beats_q[b];
      for (int l = 0; l < 8; l++) begin
        v = int'($signed(bt[l*16 +: 16]));
        if ((b == 0 && l == 0) || v > mx) begin mx = v; e.max_lane = 3'(l); e.max_beat = 16'(b); end
        if ((b == 0 && l == 0) || v < mn) begin mn = v; e.min_lane = 3'(l); e.min_beat = 16'(b); end
        case (m)
          2'd1:    acc += longint'((v * v) >>> 8);
          2'd2:    acc += longint'(v < 0 ? -v : v);
          2'd3:    acc += longint'(v);
          default: ;
        endcase
      end
    end
    if (m == 2'd0) acc = longint'(mx - mn);
    p = (acc * longint'($signed(sc))) >>> 8;
    r = p + longint'($signed(bi));
    if (r > 32767)       begin e.out = 16'h7FFF; e.ovf = 1'b1; end
    else if (r < -32768) begin e.out = 16'h8000; e.ovf = 1'b1; end
    else                 begin e.out = r[15:0];  e.ovf = 1'b0; end
    sb_q.push_back(e);
  endtask

  // Drives beats_q as one frame; later beats carry junk mode/scale/bias that must be ignored.
  // Returns right after the edge that accepted the last beat.
  task automatic send_frame(input logic [1:0] m, input logic [15:0] sc, input logic [15:0] bi);
    bit ok;
    push_expected(m, sc, bi);
    for (int b = 0; b < beats_q.size(); b++) begin
      @(negedge clk);
      mode    = (b == 0) ? m : ~m;
      scale   = (b == 0) ? sc : 16'($urandom);
      bias    = (b == 0) ? bi : 16'($urandom);
      x       = beats_q[b];
      x_valid = 1'b1;
      x_last  = (b == beats_q.size() - 1);
      ok = 1'b0;
      for (int w = 0; w < 100 && !ok; w++) begin
        if (x_ready) begin @(posedge clk); ok = 1'b1; end
        else @(negedge clk);
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL send_beat%0d: x_ready stayed 0, required 1 within 100 cycles", b);
      end
    end
    beats_q.delete();
  endtask

  // Waits for a result, scoreboards it, optionally stalls out_ready, then handshakes.
  task automatic collect(input string name, input int stall, output int lat);
    exp_t        e;
    bit          got;
    logic [68:0] snap;
    got = 1'b0; lat = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      x_valid = 1'b0; x_last = 1'b0;
      if (out_valid) got = 1'b1;
      else begin @(posedge clk); lat++; end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_timeout: out_valid=0 required 1", name);
      if (sb_q.size() != 0) void'(sb_q.pop_front());
      return;
    end
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s_unexpected: out=%h required no result", name, out);
      return;
    end
    e = sb_q.pop_front();
    checks++;
    if (out !== e.out) begin errors++; $display("FAIL %s_out: got %h required %h", name, out, e.out); end
    checks++;
    if (out_ovf !== e.ovf) begin errors++; $display("FAIL %s_ovf: got %b required %b", name, out_ovf, e.ovf); end
    checks++;
    if ({max_lane, max_beat} !== {e.max_lane, e.max_beat}) begin
      errors++;
      $display("FAIL %s_argmax: got lane %0d beat %0d required lane %0d beat %0d", name, max_lane, max_beat, e.max_lane, e.max_beat);
    end
    checks++;
    if ({min_lane, min_beat} !== {e.min_lane, e.min_beat}) begin
      errors++;
      $display("FAIL %s_argmin: got lane %0d beat %0d required lane %0d beat %0d", name, min_lane, min_beat, e.min_lane, e.min_beat);
    end
    snap = {out, max_lane, max_beat, min_lane, min_beat, out_ovf, out_valid, x_ready};
    for (int s = 0; s < stall; s++) begin
      x       = {$urandom, $urandom, $urandom, $urandom};
      mode    = 2'($urandom);
      x_valid = 1'b1;
      x_last  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({out, max_lane, max_beat, min_lane, min_beat, out_ovf, out_valid, x_ready} !== snap) begin
        errors++;
        $display("FAIL %s_stall%0d: got %h required %h", name, s,
                 {out, max_lane, max_beat, min_lane, min_beat, out_ovf, out_valid, x_ready}, snap);
      end
    end
    x_valid   = 1'b0;
    x_last    = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; mode = '0; x = '0; x_valid = 1'b0; x_last = 1'b0;
    scale = '0; bias = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({x_ready, out_valid, out_ovf, out, max_lane, max_beat, min_lane, min_beat} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0",
               {x_ready, out_valid, out_ovf, out, max_lane, max_beat, min_lane, min_beat});
    end
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (x_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", x_ready); end
  endtask

  task automatic test_range_latency();
    int lat;
    logic [127:0] b;
    b = '0;
    b[15:0] = 16'h0100; b[31:16] = 16'h0300; b[47:32] = 16'hFE00;
    beats_q.push_back(b);
    send_frame(2'd0, 16'h0100, 16'h0000);
    collect("range", 0, lat);
    checks++;
    if (lat != 3) begin errors++; $display("FAIL range_latency: got %0d required 3", lat); end
    checks++;
    if ({out, max_lane, min_lane} !== {16'h0500, 3'd1, 3'd2}) begin
      errors++;
      $display("FAIL range_const: got out %h max %0d min %0d required 0500 1 2", out, max_lane, min_lane);
    end
  endtask

  task automatic test_sumsq();
    int lat;
    repeat (2) beats_q.push_back(beat_all(16'h0100));
    send_frame(2'd1, 16'h0020, 16'h0001);
    collect("sumsq", 0, lat);
    checks++;
    if ({out, out_ovf} !== {16'h0201, 1'b0}) begin
      errors++;
      $display("FAIL sumsq_const: got %h ovf %b required 0201 ovf 0", out, out_ovf);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [127:0] b;
    repeat (2) beats_q.push_back(beat_all(16'h0010));
    send_frame(2'd3, 16'h0100, 16'hFF00);
    collect("bp_a", 5, lat);
    checks++;
    if ({x_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL bp_release: got ready %b valid %b required 1 0", x_ready, out_valid);
    end
    for (int l = 0; l < 8; l++) b[l*16 +: 16] = 16'(l * 16'h0040 - 16'h0100);
    beats_q.push_back(b);
    send_frame(2'd0, 16'h0200, 16'h0000);
    collect("bp_b", 0, lat);
    checks++;
    if (out !== 16'h0380) begin errors++; $display("FAIL bp_b_const: got %h required 0380", out); end
  endtask

  task automatic test_saturation();
    int lat;
    repeat (4) beats_q.push_back(beat_all(16'h7FFF));
    send_frame(2'd3, 16'h0100, 16'h0000);
    collect("sat_pos", 0, lat);
    checks++;
    if ({out, out_ovf} !== {16'h7FFF, 1'b1}) begin
      errors++;
      $display("FAIL sat_pos_const: got %h ovf %b required 7fff ovf 1", out, out_ovf);
    end
    repeat (4) beats_q.push_back(beat_all(16'h8000));
    send_frame(2'd3, 16'h0100, 16'h0000);
    collect("sat_neg", 0, lat);
    checks++;
    if ({out, out_ovf} !== {16'h8000, 1'b1}) begin
      errors++;
      $display("FAIL sat_neg_const: got %h ovf %b required 8000 ovf 1", out, out_ovf);
    end
  endtask

  task automatic test_ties_abs();
    int lat;
    logic [127:0] b;
    b = '0; b[63:48] = 16'h0200; beats_q.push_back(b);
    b = '0;                      beats_q.push_back(b);
    b = '0; b[31:16] = 16'h0200; beats_q.push_back(b);
    send_frame(2'd0, 16'h0100, 16'h0000);
    collect("ties", 0, lat);
    checks++;
    if ({max_lane, max_beat} !== {3'd3, 16'd0}) begin
      errors++;
      $display("FAIL ties_const: got lane %0d beat %0d required lane 3 beat 0", max_lane, max_beat);
    end
    b = '0; b[15:0] = 16'h8000; beats_q.push_back(b);
    send_frame(2'd2, 16'h0080, 16'h0000);
    collect("abs_min", 0, lat);
    checks++;
    if (out !== 16'h4000) begin errors++; $display("FAIL abs_min_const: got %h required 4000", out); end
  endtask

  task automatic test_reset_midframe();
    int lat;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      mode = 2'd3; scale = 16'h0100; bias = 16'h0000;
      x = beat_all(16'h1234); x_valid = 1'b1; x_last = 1'b0;
    end
    @(negedge clk);
    x_valid = 1'b0;
    rstn = 1'b0;
    #2;
    checks++;
    if ({x_ready, out_valid} !== 2'b00) begin
      errors++;
      $display("FAIL midrst_async: got ready %b valid %b required 0 0", x_ready, out_valid);
    end
    @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale: out_valid=%b required 0", out_valid); end
    beats_q.push_back(beat_all(16'h0100));
    send_frame(2'd3, 16'h0100, 16'h0000);
    collect("midrst", 0, lat);
    checks++;
    if (out !== 16'h0800) begin errors++; $display("FAIL midrst_const: got %h required 0800", out); end
  endtask

  initial begin
    test_reset();
    test_range_latency();
    test_sumsq();
    test_backpressure();
    test_saturation();
    test_ties_abs();
    test_reset_midframe();
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL sb_drain: %0d left required 0", sb_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
